write_burst_splitter: RTL
=========================

# write_burst_splitter

Write-side completion of burst detection: consumes the per-burst length streams produced by the upstream burst detector and drives the AXI W and B channels accordingly. The W path frames the write-data stream into bursts of `burst_len + 1` beats with `wlast`. The B path expands each single AXI write response back into `burst_len + 1` per-request acknowledgements for the kernel-side write-response FIFO. The block sits between the burst detector's `burst_len_0`/`burst_len_1` FIFOs and the AXI master port.

## Interface
- `DataWidth`, 512, width of write data and `m_axi_wdata`
- `BurstLenWidth`, 8, width of burst length; burst length value L means L+1 beats
- `clk` input 1: single clock; all logic on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `burst_len_0_dout` input BurstLenWidth: burst length for the W path
- `burst_len_0_empty_n` input 1: W-path length FIFO non-empty
- `burst_len_0_read` output 1: pop W-path length FIFO
- `burst_len_1_dout` input BurstLenWidth: burst length for the B path
- `burst_len_1_empty_n` input 1: B-path length FIFO non-empty
- `burst_len_1_read` output 1: pop B-path length FIFO
- `data_dout` input DataWidth: write data FIFO head
- `data_empty_n` input 1: write data FIFO non-empty
- `data_read` output 1: pop write data FIFO
- `m_axi_wdata` output DataWidth: AXI W data
- `m_axi_wvalid` output 1: AXI W valid
- `m_axi_wready` input 1: AXI W ready
- `m_axi_wlast` output 1: AXI W last
- `m_axi_bvalid` input 1: AXI B valid
- `m_axi_bready` output 1: AXI B ready
- `m_axi_bresp` input 2: AXI B response
- `write_resp_din` output 1: per-request ack; 1 = error (`bresp[1]` set), 0 = OK
- `write_resp_full_n` input 1: ack FIFO not full
- `write_resp_write` output 1: push ack

## Operation
- W and B paths are independent FSMs; no cross-coupling.
- **W FSM, states `W_IDLE`, `W_DATA`; register `beats_left` (BurstLenWidth).**
  - `W_IDLE`: `burst_len_0_read = burst_len_0_empty_n`. On pop, `beats_left <= burst_len_0_dout` and go to `W_DATA`.
  - `W_DATA`: combinational outputs are
    - `m_axi_wvalid = data_empty_n`
    - `m_axi_wdata = data_dout`
    - `m_axi_wlast = (beats_left == 0)`
    - `data_read = wvalid & wready`
  - On a non-last handshake: `beats_left <= beats_left - 1`.
  - On the last handshake, if `burst_len_0_empty_n`, pop the next length in the same cycle, load `beats_left`, and stay in `W_DATA` (no bubble). Otherwise go to `W_IDLE`.
- **B FSM, states `B_IDLE`, `B_WAIT`, `B_EMIT`; registers `acks_left` (BurstLenWidth) and `err` (1).**
  - `B_IDLE`: `burst_len_1_read = burst_len_1_empty_n`. On pop, `acks_left <= dout` and go to `B_WAIT`.
  - `B_WAIT`: `m_axi_bready = 1`. On `bvalid`, `err <= m_axi_bresp[1]` and go to `B_EMIT`.
  - `B_EMIT`: `write_resp_write = write_resp_full_n` and `write_resp_din = err`.
    - Each push with `acks_left != 0` decrements `acks_left`.
    - The push with `acks_left == 0` returns to `B_IDLE`.
  - `m_axi_bready = 0` in every state other than `B_WAIT`.
- **Boundaries:**
  - Length 0 is one beat with `wlast` on that beat, and exactly one ack.
  - Length all-ones (255) is 256 beats and 256 acks; the counters must not wrap early.
  - A B response arriving with `burst_len_1` empty is held off (`bready = 0`) until a length is popped.
  - B may complete before the corresponding W burst drains; no ordering check.
  - `data_empty_n` low mid-burst: `wvalid` drops and state/`beats_left` are held.
  - `write_resp_full_n` low in `B_EMIT`: no push; state is held.
- **Reset mid-operation:** both FSMs return to idle, the partial burst is abandoned, counters clear, and no further pops occur from stale state.

## Timing
- **Reset values:** both FSMs idle, `beats_left = 0`, `acks_left = 0`, `err = 0`. All outputs are 0 during reset: `*_read`, `m_axi_wvalid`, `m_axi_wlast`, `m_axi_bready`, `write_resp_write`, `write_resp_din`, `m_axi_wdata`.
- **W latency:** length pop in cycle N; the first beat can handshake in cycle N+1. Back-to-back bursts sustain 1 beat/cycle, including across burst boundaries.
- **B latency:**
  - Length pop in cycle N.
  - `bready` high from cycle N+1.
  - B handshake in cycle M gives the first ack push in cycle M+1.
  - Acks are then pushed at 1/cycle when not full.
  - Return to `B_IDLE` the cycle after the final push; the next length pop is one cycle later (one-cycle bubble per burst).
- **Combinational paths:** all outputs are combinational from registered state plus the same-cycle FIFO/AXI inputs named above. No input-to-output path spans FSMs.

## Test plan
- Lengths {3}, 4 data words D0..D3, `wready` = 1 → 4 beats on consecutive cycles, `wlast` only with D3, one length pop, 4 data pops.
- Lengths {0, 1} queued, `wready` = 1 → beats D0(last), D1, D2(last) in three consecutive cycles; second length popped in the same cycle as D0.
- `burst_len_1` = {2}, `bresp` = 0 → exactly 3 `write_resp` pushes of 0 on cycles M+1..M+3; `bready` = 0 afterwards until the next length.
- `burst_len_1` = {255}, `bresp` = 2'b10, `write_resp_full_n` toggling 50% → exactly 256 pushes, all `din` = 1, none lost or duplicated.
- `bvalid` held high with `burst_len_1` empty for 10 cycles → `bready` stays 0. Length 0 then arrives → handshake 2 cycles later, one ack.
- `rst_n` low mid-burst (after 2 of 8 beats, and during `B_EMIT`) → all outputs 0 on the next cycle. After release, a new length {1} produces 2 correctly framed beats and 2 acks.

Source files
------------

// File: rtl/write_burst_splitter.sv
// -----------------------------------------------------------------------------
// write_burst_splitter
//
// Purpose:
//   Write-side completion of burst detection. Two independent FSMs:
//   - W path: frames the write-data FIFO stream into AXI W bursts of
//     (burst_len + 1) beats, asserting m_axi_wlast on the final beat. Bursts
//     are chained without a bubble when the next length is already queued.
//   - B path: expands each single AXI B response into (burst_len + 1)
//     per-request acknowledgements pushed into the write-response FIFO.
//
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   burst_len_0_*              W-path burst length FIFO (dout/empty_n/read)
//   burst_len_1_*              B-path burst length FIFO (dout/empty_n/read)
//   data_*                     write data FIFO (dout/empty_n/read)
//   m_axi_w*                   AXI W channel (wdata/wvalid/wready/wlast)
//   m_axi_b*                   AXI B channel (bvalid/bready/bresp)
//   write_resp_*               per-request ack FIFO (din/full_n/write)
//
// All outputs are combinational from registered state plus same-cycle FIFO /
// AXI inputs of the owning path, and are forced to 0 while rst_n is low.
// -----------------------------------------------------------------------------
module write_burst_splitter #(
  parameter int DataWidth     = 512,
  parameter int BurstLenWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BurstLenWidth-1:0] burst_len_0_dout,
  input  logic                     burst_len_0_empty_n,
  output logic                     burst_len_0_read,
  input  logic [BurstLenWidth-1:0] burst_len_1_dout,
  input  logic                     burst_len_1_empty_n,
  output logic                     burst_len_1_read,
  input  logic [DataWidth-1:0]     data_dout,
  input  logic                     data_empty_n,
  output logic                     data_read,
  output logic [DataWidth-1:0]     m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  output logic                     m_axi_wlast,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  input  logic [1:0]               m_axi_bresp,
  output logic                     write_resp_din,
  input  logic                     write_resp_full_n,
  output logic                     write_resp_write
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_DATA = 1'b1;

  localparam logic [1:0] B_IDLE = 2'd0;
  localparam logic [1:0] B_WAIT = 2'd1;
  localparam logic [1:0] B_EMIT = 2'd2;

  localparam logic [BurstLenWidth-1:0] LEN_ZERO = {BurstLenWidth{1'b0}};
  localparam logic [BurstLenWidth-1:0] LEN_ONE  = {{(BurstLenWidth-1){1'b0}}, 1'b1};
  localparam logic [DataWidth-1:0]     DATA_ZERO = {DataWidth{1'b0}};

  // W path state
  logic [0:0]               w_state_q, w_state_d;
  logic [BurstLenWidth-1:0] beats_left_q, beats_left_d;

  // B path state
  logic [1:0]               b_state_q, b_state_d;
  logic [BurstLenWidth-1:0] acks_left_q, acks_left_d;
  logic                     err_q, err_d;

  // Ungated combinational outputs
  logic                 len0_read_s;
  logic                 data_read_s;
  logic                 wvalid_s;
  logic                 wlast_s;
  logic [DataWidth-1:0] wdata_s;
  logic                 w_hs_s;
  logic                 len1_read_s;
  logic                 bready_s;
  logic                 resp_write_s;
  logic                 resp_din_s;

  // Only the error bit of the response matters; OKAY/EXOKAY are both success.
  logic                 bresp_unused_s;
  assign bresp_unused_s = m_axi_bresp[0];

  // W path next-state and output decode.
  always_comb begin
    w_state_d    = w_state_q;
    beats_left_d = beats_left_q;
    len0_read_s  = 1'b0;
    wvalid_s     = 1'b0;
    wlast_s      = 1'b0;
    wdata_s      = DATA_ZERO;
    w_hs_s       = 1'b0;
    data_read_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        len0_read_s = burst_len_0_empty_n;
        if (burst_len_0_empty_n) begin
          beats_left_d = burst_len_0_dout;
          w_state_d    = W_DATA;
        end else begin
          w_state_d    = W_IDLE;
        end
      end
      W_DATA: begin
        wvalid_s    = data_empty_n;
        wdata_s     = data_dout;
        wlast_s     = (beats_left_q == LEN_ZERO);
        w_hs_s      = data_empty_n & m_axi_wready;
        data_read_s = w_hs_s;
        if (w_hs_s && wlast_s) begin
          // Chain straight into the next burst when its length is waiting,
          // so the W channel keeps one beat per cycle across boundaries.
          if (burst_len_0_empty_n) begin
            len0_read_s  = 1'b1;
            beats_left_d = burst_len_0_dout;
          end else begin
            w_state_d    = W_IDLE;
          end
        end else if (w_hs_s) begin
          beats_left_d = beats_left_q - LEN_ONE;
        end else begin
          beats_left_d = beats_left_q;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // B path next-state and output decode.
  always_comb begin
    b_state_d    = b_state_q;
    acks_left_d  = acks_left_q;
    err_d        = err_q;
    len1_read_s  = 1'b0;
    bready_s     = 1'b0;
    resp_write_s = 1'b0;
    resp_din_s   = 1'b0;
    case (b_state_q)
      B_IDLE: begin
        len1_read_s = burst_len_1_empty_n;
        if (burst_len_1_empty_n) begin
          acks_left_d = burst_len_1_dout;
          b_state_d   = B_WAIT;
        end else begin
          b_state_d   = B_IDLE;
        end
      end
      B_WAIT: begin
        bready_s = 1'b1;
        if (m_axi_bvalid) begin
          err_d     = m_axi_bresp[1];
          b_state_d = B_EMIT;
        end else begin
          b_state_d = B_WAIT;
        end
      end
      B_EMIT: begin
        resp_write_s = write_resp_full_n;
        resp_din_s   = err_q;
        if (write_resp_full_n) begin
          // Down-count to zero so length 255 yields 256 pushes without wrap.
          if (acks_left_q == LEN_ZERO) begin
            b_state_d = B_IDLE;
          end else begin
            acks_left_d = acks_left_q - LEN_ONE;
          end
        end else begin
          b_state_d = B_EMIT;
        end
      end
      default: begin
        b_state_d = B_IDLE;
      end
    endcase
  end

  // State registers for both paths with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q    <= W_IDLE;
      beats_left_q <= LEN_ZERO;
      b_state_q    <= B_IDLE;
      acks_left_q  <= LEN_ZERO;
      err_q        <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      beats_left_q <= beats_left_d;
      b_state_q    <= b_state_d;
      acks_left_q  <= acks_left_d;
      err_q        <= err_d;
    end
  end

  // Outputs are held at 0 for the whole time reset is asserted, including the
  // first reset cycle before the state registers have been cleared.
  assign burst_len_0_read = rst_n & len0_read_s;
  assign data_read        = rst_n & data_read_s;
  assign m_axi_wvalid     = rst_n & wvalid_s;
  assign m_axi_wlast      = rst_n & wlast_s;
  assign m_axi_wdata      = rst_n ? wdata_s : DATA_ZERO;
  assign burst_len_1_read = rst_n & len1_read_s;
  assign m_axi_bready     = rst_n & bready_s;
  assign write_resp_write = rst_n & resp_write_s;
  assign write_resp_din   = rst_n & resp_din_s;

endmodule
